// File: rtl/multiplier_arbiter_if.sv
// rtl/multiplier_arbiter_if.sv - requester, response and shared-multiplier signals of the multiplier arbiter
interface multiplier_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [63:0] rsp0_data;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [63:0] rsp1_data;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_p;
  logic        busy;

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, mul_p,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  mul_a, mul_b, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, mul_p,
    output req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output mul_a, mul_b, busy
  );
endinterface

// File: rtl/multiplier_arbiter.sv
// rtl/multiplier_arbiter.sv - two-requester arbiter in front of a shared LAT-cycle multiplier
// Optional MULTIPLIER_ARBITER_FIXED_PRIO_EN: requester 0 always wins contention, no round-robin pointer.
module multiplier_arbiter #(
  parameter int LAT = 2
) (
  input logic                clk,
  input logic                rst,
  multiplier_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } slot_t;

  slot_t slot0, slot1, slot0_next, slot1_next;
  logic elig0, elig1, grant0, grant1;
  logic out0, out1;
  logic [LAT-1:0] tag_valid;
  logic [LAT-1:0] tag_id;
  logic [63:0] rsp0_data, rsp1_data;
`ifndef MULTIPLIER_ARBITER_FIXED_PRIO_EN
  logic prio1;
`endif

  always_comb begin
    elig0 = bus.req0_valid && (slot0 == IDLE);
    elig1 = bus.req1_valid && (slot1 == IDLE);
`ifdef MULTIPLIER_ARBITER_FIXED_PRIO_EN
    grant0 = elig0;
    grant1 = elig1 && !elig0;
`else
    grant0 = elig0 && (!elig1 || !prio1);
    grant1 = elig1 && (!elig0 || prio1);
`endif
  end

  // The oldest tag entry identifies whose product is on mul_p this cycle.
  assign out0 = tag_valid[LAT-1] && !tag_id[LAT-1];
  assign out1 = tag_valid[LAT-1] &&  tag_id[LAT-1];

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.mul_a      = grant0 ? bus.req0_a : (grant1 ? bus.req1_a : 32'd0);
  assign bus.mul_b      = grant0 ? bus.req0_b : (grant1 ? bus.req1_b : 32'd0);
  assign bus.rsp0_valid = (slot0 == DONE);
  assign bus.rsp1_valid = (slot1 == DONE);
  assign bus.rsp0_data  = rsp0_data;
  assign bus.rsp1_data  = rsp1_data;
  assign bus.busy       = (slot0 != IDLE) || (slot1 != IDLE);

  always_comb begin
    slot0_next = slot0;
    slot1_next = slot1;
    case (slot0)
      IDLE:    if (grant0) slot0_next = BUSY;
      BUSY:    if (out0) slot0_next = DONE;
      DONE:    if (bus.rsp0_ready) slot0_next = IDLE;
      default: slot0_next = IDLE;
    endcase
    case (slot1)
      IDLE:    if (grant1) slot1_next = BUSY;
      BUSY:    if (out1) slot1_next = DONE;
      DONE:    if (bus.rsp1_ready) slot1_next = IDLE;
      default: slot1_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0     <= IDLE;
      slot1     <= IDLE;
      tag_valid <= '0;
      tag_id    <= '0;
      rsp0_data <= 64'd0;
      rsp1_data <= 64'd0;
`ifndef MULTIPLIER_ARBITER_FIXED_PRIO_EN
      prio1     <= 1'b0;
`endif
    end else begin
      slot0 <= slot0_next;
      slot1 <= slot1_next;
      for (int i = LAT - 1; i > 0; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
      tag_valid[0] <= grant0 || grant1;
      tag_id[0]    <= grant1;
      if ((slot0 == BUSY) && out0) rsp0_data <= bus.mul_p;
      if ((slot1 == BUSY) && out1) rsp1_data <= bus.mul_p;
`ifndef MULTIPLIER_ARBITER_FIXED_PRIO_EN
      if (grant0) prio1 <= 1'b1;
      else if (grant1) prio1 <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_multiplier_arbiter.sv
// tb/tb_multiplier_arbiter.sv - directed scoreboard bench for multiplier_arbiter
module tb_multiplier_arbiter;
  localparam int LAT = 2;
`ifdef MULTIPLIER_ARBITER_FIXED_PRIO_EN
  localparam logic FIXED = 1'b1;
`else
  localparam logic FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multiplier_arbiter_if bus ();
  multiplier_arbiter #(.LAT(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
    for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_p = mpipe[LAT-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int gcount0;
  int glog [$];
  logic [63:0] q0 [$];
  logic [63:0] q1 [$];
  logic s_g0, s_g1, s_v0, s_v1, s_busy;
  logic [31:0] s_ma, s_mb;
  logic [63:0] s_d0, s_d1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    s_g0 = bus.req0_ready;  s_g1 = bus.req1_ready;
    s_v0 = bus.rsp0_valid;  s_v1 = bus.rsp1_valid;
    s_d0 = bus.rsp0_data;   s_d1 = bus.rsp1_data;
    s_ma = bus.mul_a;       s_mb = bus.mul_b;
    s_busy = bus.busy;
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (bus.req0_valid && bus.req0_ready) begin
        q0.push_back({32'd0, bus.req0_a} * {32'd0, bus.req0_b});
        glog.push_back(0);
      end
      if (bus.req1_valid && bus.req1_ready) begin
        q1.push_back({32'd0, bus.req1_a} * {32'd0, bus.req1_b});
        glog.push_back(1);
      end
      if (bus.rsp0_valid && bus.rsp0_ready) begin
        chk("sb0_pending", 64'(q0.size() != 0), 64'd1);
        if (q0.size() != 0) chk("sb0_data", bus.rsp0_data, q0.pop_front());
      end
      if (bus.rsp1_valid && bus.rsp1_ready) begin
        chk("sb1_pending", 64'(q1.size() != 0), 64'd1);
        if (q1.size() != 0) chk("sb1_data", bus.rsp1_data, q1.pop_front());
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (s_busy && n < 30);
    chk(tag, 64'(s_busy), 64'd0);
    chk({tag, "_sb_empty"}, 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0;
    bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    step();
    step();
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_v0", 64'(s_v0), 64'd0);
    chk("rst_v1", 64'(s_v1), 64'd0);
    chk("rst_d0", s_d0, 64'd0);
    chk("rst_d1", s_d1, 64'd0);
    rst = 1'b0;
    step();
    chk("idle_mul_a", 64'(s_ma), 64'd0);
    chk("idle_ready", 64'({s_g0, s_g1}), 64'd0);

    // single request
    bus.req0_valid = 1'b1; bus.req0_a = 32'd3; bus.req0_b = 32'd5;
    step();
    chk("single_grant", 64'({s_g0, s_g1}), 64'b10);
    chk("single_mul_a", 64'(s_ma), 64'd3);
    chk("single_mul_b", 64'(s_mb), 64'd5);
    bus.req0_valid = 1'b0;
    step();
    chk("single_v0_t1", 64'(s_v0), 64'd0);
    step();
    chk("single_v0_t2", 64'(s_v0), 64'd0);
    step();
    chk("single_v0_t3", 64'(s_v0), 64'd1);
    chk("single_d0_t3", s_d0, 64'd15);
    step();
    chk("single_busy_after", 64'(s_busy), 64'd0);

    // contention right after requester 0 was last granted
    bus.req0_valid = 1'b1; bus.req0_a = 32'd2; bus.req0_b = 32'd3;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd4; bus.req1_b = 32'd5;
    step();
    chk("rr_grant", 64'({s_g0, s_g1}), FIXED ? 64'b10 : 64'b01);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain("rr_drain");

    // contention from reset
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd6;
    bus.req1_valid = 1'b1; bus.req1_a = 32'hFFFF_FFFF; bus.req1_b = 32'hFFFF_FFFF;
    step();
    chk("cont_grant_t0", 64'({s_g0, s_g1}), 64'b10);
    step();
    chk("cont_grant_t1", 64'({s_g0, s_g1}), 64'b01);
    chk("cont_mul_a_t1", 64'(s_ma), 64'hFFFF_FFFF);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    step();
    step();
    chk("cont_v0_t3", 64'(s_v0), 64'd1);
    chk("cont_d0_t3", s_d0, 64'd42);
    step();
    chk("cont_v1_t4", 64'(s_v1), 64'd1);
    chk("cont_d1_t4", s_d1, 64'hFFFF_FFFE_0000_0001);
    drain("cont_drain");

    // response backpressure on requester 1
    bus.rsp1_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd1000; bus.req1_b = 32'd2000;
    step();
    chk("bp_grant1", 64'(s_g1), 64'd1);
    step();
    step();
    step();
    chk("bp_v1_rise", 64'(s_v1), 64'd1);
    chk("bp_d1_rise", s_d1, 64'd2_000_000);
    bus.req0_valid = 1'b1; bus.req0_a = 32'd11; bus.req0_b = 32'd13;
    gcount0 = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_v1_hold", 64'(s_v1), 64'd1);
      chk("bp_d1_hold", s_d1, 64'd2_000_000);
      chk("bp_ready1_low", 64'(s_g1), 64'd0);
      if (s_g0) gcount0++;
    end
    chk("bp_req0_grants", 64'(gcount0), 64'd2);
    bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain("bp_drain");

    // fairness with random operands
    rst = 1'b1;
    step();
    rst = 1'b0;
    glog.delete();
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    for (int n = 0; n < 40 && glog.size() < 4; n++) begin
      bus.req0_a = $urandom(); bus.req0_b = $urandom();
      bus.req1_a = $urandom(); bus.req1_b = $urandom();
      step();
    end
    chk("fair_count", 64'(glog.size()), 64'd4);
    if (glog.size() >= 4) begin
      for (int k = 0; k < 4; k++) chk("fair_order", 64'(glog[k]), 64'(k % 2));
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    drain("fair_drain");

    // reset while a product is in flight
    bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9;
    step();
    chk("mid_grant", 64'(s_g0), 64'd1);
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("mid_v0_quiet", 64'(s_v0), 64'd0);
      chk("mid_busy", 64'(s_busy), 64'd0);
    end
    bus.req0_valid = 1'b1; bus.req0_a = 32'd4; bus.req0_b = 32'd25;
    step();
    chk("mid_regrant", 64'(s_g0), 64'd1);
    bus.req0_valid = 1'b0;
    step();
    step();
    step();
    chk("mid_v0_after", 64'(s_v0), 64'd1);
    chk("mid_d0_after", s_d0, 64'd100);
    drain("mid_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 Parameter LAT, default 2, fixed cycles from driving mul_a/mul_b to the matching mul_p; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 reqN_valid  input  1  requester N (N in {0,1}) presents an operand pair.
REQ-005 reqN_ready  output  1  requester N's operands are accepted this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  unsigned operands of requester N.
REQ-007 rspN_valid  output  1  rspN_data holds a valid product for requester N.
REQ-008 rspN_ready  input  1  requester N consumes its product.
REQ-009 rspN_data  output  64  unsigned product for requester N.
REQ-010 mul_a, mul_b  output  32 each  operands to the shared multiplier.
REQ-011 mul_p  input  64  product from the shared multiplier.
REQ-012 busy  output  1  high when any requester slot is not IDLE.

Function
REQ-013 Each requester N has a 3-state slot FSM: IDLE, BUSY (product in flight) and DONE (product held in rspN_data).
REQ-014 Slot transitions: IDLE->BUSY on handshake (reqN_valid && reqN_ready); BUSY->DONE when its product is captured; DONE->IDLE on rspN_valid && rspN_ready; all other cases hold.
REQ-015 Requester N is eligible when reqN_valid=1 and slot N is IDLE; at most one requester is granted per cycle.
REQ-016 reqN_ready=1 only in the cycle requester N is eligible and granted; reqN_ready may depend combinationally on req0_valid/req1_valid.
REQ-017 Arbitration is round-robin: if both are eligible, the one not granted most recently wins; a sole eligible requester always wins.
REQ-018 In the handshake cycle, mul_a/mul_b = granted reqN_a/reqN_b; with no grant, mul_a = mul_b = 0.
REQ-019 A LAT-deep tag pipeline (valid bit plus requester id) advances every cycle; the entry leaving it marks mul_p as belonging to that requester.
REQ-020 mul_p is captured into rspN_data at the end of the cycle exactly LAT cycles after the handshake; rspN_valid rises the next cycle (handshake-to-rspN_valid = LAT+1 cycles).
REQ-021 rspN_data and rspN_valid hold stable while rspN_valid=1 and rspN_ready=0.
REQ-022 rspN_ready with slot N not DONE has no effect.
REQ-023 A slot freed by a response handshake can accept a new request from the following cycle, not the same cycle.
REQ-024 Back-to-back issue is permitted: requesters 0 and 1 may be granted on consecutive cycles, and both products may be in flight at once.
REQ-025 The product is the full 64-bit unsigned result; no truncation or saturation.

Reset
REQ-026 With rst=1 at a rising edge: both slots go IDLE, the tag pipeline is cleared, the round-robin pointer gives priority to requester 0, rspN_data=0, and rspN_valid=reqN_ready=busy=0.
REQ-027 Reset mid-operation discards all in-flight products; mul_p values arriving after reset without a matching tag are ignored.

Configuration
REQ-028 Macro MULTIPLIER_ARBITER_FIXED_PRIO_EN: when defined, requester 0 always wins when both are eligible (fixed priority) and the round-robin pointer is not implemented; when undefined, REQ-017 applies.

Verification
REQ-029 Single request: req0 a=3, b=5 accepted at cycle t -> mul_a=3, mul_b=5 at t; rsp0_valid=1 and rsp0_data=15 at t+3 (LAT=2).
REQ-030 Contention: both valid at t and t+1 from reset, with req0 (7,6) and req1 (0xFFFFFFFF,0xFFFFFFFF) -> req0 granted at t, req1 at t+1; rsp0_data=42 at t+3; rsp1_data=0xFFFFFFFE00000001 at t+4.
REQ-031 Backpressure: rsp1_ready held 0 for 5 cycles after rsp1_valid -> rsp1_data stable throughout, req1_ready=0 throughout, and req0 traffic continues unaffected.
REQ-032 Fairness: both requesters continuously valid, responses always ready -> grants alternate 0,1,0,1; with MULTIPLIER_ARBITER_FIXED_PRIO_EN defined, requester 0 wins every contended cycle.
REQ-033 Reset mid-flight: rst asserted one cycle after the req0 handshake -> rsp0_valid never asserts, busy=0 after reset, and the next request completes correctly.
